// File: rtl/acc_diag_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : acc_diag_rd_addr_gen (with acc_diag_rd_addr_gen_pkg)
// Brief    : Per-column read enable/address generator for the 32-column
//            accumulator bank. NORMAL mode reads the same row on every column;
//            DIAG mode skews column c by c rows to follow the systolic
//            wavefront. Registered outputs, downstream backpressure.
// Revision : 1.0 - initial release
// ============================================================================

package acc_diag_rd_addr_gen_pkg;
  localparam int ACC_N_COLS = 32;
  localparam int ACC_ADDR_W = 7;

  typedef enum logic {
    NORMAL = 1'b0,
    DIAG   = 1'b1
  } acc_rd_mode;

  typedef logic [ACC_N_COLS-1:0][ACC_ADDR_W-1:0] diag_addr_array_t;
endpackage

module acc_diag_rd_addr_gen
  import acc_diag_rd_addr_gen_pkg::*;
#(
  parameter int N_COLS = ACC_N_COLS,
  parameter int ADDR_W = ACC_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  acc_rd_mode       mode_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   num_rows_i,
  input  logic             out_ready_i,
  output logic [N_COLS-1:0] rd_en_o,
  output diag_addr_array_t rd_addr_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  acc_rd_mode        r_mode;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W:0]   r_rows;
  logic [7:0]        r_t;

  logic              w_accept;
  logic              w_consume;
  logic              w_last;
  logic              w_load;
  logic [8:0]        w_total;

  // Source of the step being prepared: fresh inputs on accept, latched fields otherwise
  acc_rd_mode        w_src_mode;
  logic [ADDR_W-1:0] w_src_base;
  logic [ADDR_W:0]   w_src_rows;
  logic [7:0]        w_src_t;

  logic [N_COLS-1:0] w_step_en;
  diag_addr_array_t  w_step_addr;

  assign w_accept  = (r_state == S_IDLE) && start_i;
  assign w_consume = (r_state == S_RUN) && out_ready_i;
  // DIAG needs N_COLS-1 extra steps for the skew to drain through the last column
  assign w_total   = (r_mode == DIAG) ? ({1'b0, r_rows} + 9'(N_COLS - 1)) : {1'b0, r_rows};
  assign w_last    = w_consume && (({1'b0, r_t} + 9'd1) == w_total);
  assign w_load    = (w_accept && (num_rows_i != '0)) || w_consume;

  assign w_src_mode = w_accept ? mode_i      : r_mode;
  assign w_src_base = w_accept ? base_addr_i : r_base;
  assign w_src_rows = w_accept ? num_rows_i  : r_rows;
  assign w_src_t    = w_accept ? 8'd0        : (r_t + 8'd1);

  // Per-column enable/address for step w_src_t; disabled columns drive address 0
  for (genvar c = 0; c < N_COLS; c++) begin : g_col
    logic [8:0] w_k;
    logic       w_hit;
    always_comb begin
      w_k   = {1'b0, w_src_t} - 9'(c);
      w_hit = (w_src_t >= 8'(c)) && (w_k < {1'b0, w_src_rows});
      if (w_src_mode == NORMAL) begin
        w_k   = {1'b0, w_src_t};
        w_hit = 1'b1;
      end
    end
    assign w_step_en[c]   = w_hit;
    assign w_step_addr[c] = w_hit ? (w_src_base + w_k[ADDR_W-1:0]) : '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_state_next = (num_rows_i == '0) ? S_DONE : S_RUN;
      S_RUN:  if (w_last)  w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch run parameters at accept and advance the step counter on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= NORMAL;
      r_base <= '0;
      r_rows <= '0;
      r_t    <= '0;
    end else if (w_accept) begin
      r_mode <= mode_i;
      r_base <= base_addr_i;
      r_rows <= num_rows_i;
      r_t    <= '0;
    end else if (w_consume) begin
      r_t    <= r_t + 8'd1;
    end
  end

  // Output step register: load the next step, clear once the last step is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_o   <= '0;
      rd_addr_o <= '0;
    end else if (w_last) begin
      rd_en_o   <= '0;
      rd_addr_o <= '0;
    end else if (w_load) begin
      rd_en_o   <= w_step_en;
      rd_addr_o <= w_step_addr;
    end
  end

  // Registered status flags derived from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      busy_o <= (w_state_next != S_IDLE);
      done_o <= (w_state_next == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_acc_diag_rd_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_acc_diag_rd_addr_gen
// Brief    : Self-checking bench for acc_diag_rd_addr_gen: table of runs with
//            expected completion cycle, reference model feeding a step queue,
//            spot checks of captured steps, and a mid-run reset sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_acc_diag_rd_addr_gen;
  import acc_diag_rd_addr_gen_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start_i;
  acc_rd_mode       mode_i;
  logic [6:0]       base_addr_i;
  logic [7:0]       num_rows_i;
  logic             out_ready_i;
  logic [31:0]      rd_en_o;
  diag_addr_array_t rd_addr_o;
  logic             busy_o;
  logic             done_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0]      en;
    diag_addr_array_t addr;
  } step_t;

  typedef struct {
    acc_rd_mode mode;
    int         base;
    int         rows;
    int         stall_at;
    int         stall_len;
    int         busy_start;
    int         exp_done;
  } vec_t;

  step_t cap [0:199];
  vec_t  vecs [9];
  int    wrap_exp [4];

  acc_diag_rd_addr_gen #(.N_COLS(32), .ADDR_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .mode_i      (mode_i),
    .base_addr_i (base_addr_i),
    .num_rows_i  (num_rows_i),
    .out_ready_i (out_ready_i),
    .rd_en_o     (rd_en_o),
    .rd_addr_o   (rd_addr_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [257:0] act, input logic [257:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: column c reads row base+k where k = t (NORMAL) or t-c (DIAG)
  function automatic step_t model_step(input acc_rd_mode m, input int base, input int rows, input int t);
    step_t s;
    int    k;
    s.en   = '0;
    s.addr = '0;
    for (int c = 0; c < 32; c++) begin
      k = (m == NORMAL) ? t : t - c;
      if (k >= 0 && k < rows) begin
        s.en[c]   = 1'b1;
        s.addr[c] = 7'((base + k) % 128);
      end
    end
    return s;
  endfunction

  task automatic scramble_inputs();
    mode_i      = acc_rd_mode'($urandom_range(0, 1));
    base_addr_i = 7'($urandom);
    num_rows_i  = 8'($urandom_range(0, 128));
  endtask

  // Drive one run; expected steps are queued at start and popped as each is consumed
  task automatic run_case(input vec_t v, input int idx);
    step_t q[$];
    step_t cur;
    int    cyc;
    int    popped;
    int    stalled;
    int    nsteps;
    nsteps = (v.mode == DIAG && v.rows > 0) ? v.rows + 31 : v.rows;
    @(negedge clk);
    start_i     = 1'b1;
    mode_i      = v.mode;
    base_addr_i = 7'(v.base);
    num_rows_i  = 8'(v.rows);
    out_ready_i = 1'b1;
    for (int t = 0; t < nsteps; t++) q.push_back(model_step(v.mode, v.base, v.rows, t));
    @(negedge clk);
    start_i = 1'b0;
    scramble_inputs();
    cyc     = 1;
    popped  = 0;
    stalled = 0;
    while (q.size() > 0 && cyc < 400) begin
      cur = q[0];
      check($sformatf("case%0d step%0d", idx, popped),
            {busy_o, done_o, rd_en_o, rd_addr_o}, {2'b10, cur});
      cap[popped] = {rd_en_o, rd_addr_o};
      if (popped == v.stall_at && stalled < v.stall_len) begin
        out_ready_i = 1'b0;
        stalled++;
      end else begin
        out_ready_i = 1'b1;
        void'(q.pop_front());
        popped++;
      end
      start_i = (v.busy_start != 0 && cyc == v.busy_start);
      if (start_i) scramble_inputs();
      @(negedge clk);
      cyc++;
    end
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    check($sformatf("case%0d timeout steps_left", idx), q.size(), 0);
    check($sformatf("case%0d done state", idx),
          {busy_o, done_o, rd_en_o, rd_addr_o}, {2'b11, 256'd0});
    check($sformatf("case%0d done cycle", idx), cyc, v.exp_done);
    @(negedge clk);
    check($sformatf("case%0d idle after done", idx),
          {busy_o, done_o, rd_en_o, rd_addr_o}, 258'd0);
  endtask

  task automatic spot_checks(input int idx);
    if (idx == 0) begin
      check("n10 step3 col31 addr", cap[3].addr[31], 13);
    end
    if (idx == 1) begin
      check("diag step0 en", cap[0].en, 32'h0000_0001);
      check("diag step0 col0", cap[0].addr[0], 0);
      check("diag step2 col0", cap[2].addr[0], 2);
      check("diag step2 col1", cap[2].addr[1], 1);
      check("diag step2 col2", cap[2].addr[2], 0);
      check("diag step33 en", cap[33].en, 32'h8000_0000);
      check("diag step33 col31", cap[33].addr[31], 2);
    end
    if (idx == 2) begin
      for (int t = 0; t < 4; t++) check($sformatf("wrap normal t%0d", t), cap[t].addr[0], wrap_exp[t]);
    end
    if (idx == 3) begin
      for (int t = 0; t < 4; t++) check($sformatf("wrap diag col5 t%0d", t+5), cap[t+5].addr[5], wrap_exp[t]);
    end
  endtask

  initial begin
    step_t exp_s;
    wrap_exp = '{126, 127, 0, 1};
    //            mode    base rows st_at st_len bstart done
    vecs[0] = '{NORMAL,  10,   4,   0,    0,     0,    5};
    vecs[1] = '{DIAG,     0,   3,   0,    0,     0,   35};
    vecs[2] = '{NORMAL, 126,   4,   0,    0,     0,    5};
    vecs[3] = '{DIAG,   126,   4,   0,    0,     0,   36};
    vecs[4] = '{DIAG,     5,   2,   1,    3,     0,   37};
    vecs[5] = '{NORMAL,  20,   6,   0,    0,     3,    7};
    vecs[6] = '{DIAG,     0,   0,   0,    0,     0,    1};
    vecs[7] = '{NORMAL,   0, 128,   0,    0,     0,  129};
    vecs[8] = '{DIAG,   100, 128,  50,    2,    20,  162};

    rst_n       = 1'b1;
    start_i     = 1'b0;
    mode_i      = NORMAL;
    base_addr_i = '0;
    num_rows_i  = '0;
    out_ready_i = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset outputs", {busy_o, done_o, rd_en_o, rd_addr_o}, 258'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset idle", {busy_o, done_o, rd_en_o, rd_addr_o}, 258'd0);

    for (int i = 0; i < 9; i++) begin
      run_case(vecs[i], i);
      spot_checks(i);
    end

    // Reset in the middle of a DIAG run at step 10
    @(negedge clk);
    start_i     = 1'b1;
    mode_i      = DIAG;
    base_addr_i = 7'd0;
    num_rows_i  = 8'd20;
    out_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int t = 0; t <= 10; t++) begin
      exp_s = model_step(DIAG, 0, 20, t);
      check($sformatf("rst run step%0d", t), {busy_o, done_o, rd_en_o, rd_addr_o}, {2'b10, exp_s});
      if (t < 10) @(negedge clk);
    end
    rst_n = 1'b0;
    #1 check("async reset mid-run", {busy_o, done_o, rd_en_o, rd_addr_o}, 258'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("after reset release", {busy_o, done_o, rd_en_o, rd_addr_o}, 258'd0);
    run_case('{NORMAL, 7, 1, 0, 0, 0, 2}, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
